// File: rtl/tmul_pkg.sv
// rtl/tmul_pkg.sv - shared types and constants for the tile multiplier result drain
package tmul_pkg;

    localparam int TMUL_COLS  = 8;
    localparam int TMUL_ACC_W = 64;

    typedef logic [TMUL_COLS-1:0][TMUL_ACC_W-1:0] c_tile_t;
    typedef logic [2:0] beat_idx_t;

    localparam beat_idx_t BEAT_LAST = 3'd7;

endpackage

// File: rtl/tmul_result_drain_if.sv
// rtl/tmul_result_drain_if.sv - issue/capture/beat-stream bundle; slave is the drain side
interface tmul_result_drain_if;
    import tmul_pkg::*;

    logic      issue_valid;
    logic      issue_ready;
    c_tile_t   c_in;
    logic      out_valid;
    logic      out_ready;
    logic [TMUL_ACC_W-1:0] out_data;
    beat_idx_t out_idx;
    logic      out_last;

    modport slave (
        input  issue_valid, c_in, out_ready,
        output issue_ready, out_valid, out_data, out_idx, out_last
    );

    modport master (
        output issue_valid, c_in, out_ready,
        input  issue_ready, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/tmul_tile_fifo.sv
// rtl/tmul_tile_fifo.sv - DEPTH-entry tile FIFO with a registered head-of-queue output
module tmul_tile_fifo
    import tmul_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  c_tile_t                    i_wdata,
    input  logic                       i_pop,
    output c_tile_t                    o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    c_tile_t          r_mem [DEPTH];
    c_tile_t          r_rdata;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_rd_next;

    // DEPTH need not be a power of two, so wrap by compare rather than overflow
    function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_rd_next = f_wrap(r_rd_ptr);

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= f_wrap(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= w_rd_next;
            if (i_push && !i_pop)      r_count <= r_count + 1'b1;
            else if (!i_pop && !i_push) r_count <= r_count;
            else if (i_pop && !i_push)  r_count <= r_count - 1'b1;
            // Head register follows the entry that will be at the front next cycle
            if (i_push && (r_count == '0 || (i_pop && r_count == CNT_W'(1))))
                r_rdata <= i_wdata;
            else if (i_pop && r_count > CNT_W'(1))
                r_rdata <= r_mem[w_rd_next];
        end
    end

    assign o_rdata = r_rdata;
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/tmul_result_drain.sv
// rtl/tmul_result_drain.sv - token pipe, credits, tile buffer and beat sequencer; err port with TMUL_DRAIN_ERR_EN
module tmul_result_drain
    import tmul_pkg::*;
#(
    parameter int LATENCY = 8,
    parameter int DEPTH   = 2
) (
    input  logic clk,
    input  logic rst,
`ifdef TMUL_DRAIN_ERR_EN
    output logic err,
`endif
    tmul_result_drain_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [LATENCY-1:0] r_tok;
    logic [CNT_W-1:0]   r_outstanding;
    logic [0:0]         r_state;
    beat_idx_t          r_idx;

    logic       w_issue_ready;
    logic       w_issue_acc;
    logic       w_capture;
    logic       w_beat_hs;
    logic       w_tile_done;
    logic       w_more;
    logic       w_full;
    logic       w_empty;
    logic [CNT_W-1:0] w_fifo_count;
    c_tile_t    w_head;

    assign w_issue_ready = (r_outstanding < CNT_W'(DEPTH));
    assign w_issue_acc   = bus.issue_valid && w_issue_ready;
    // Credits guarantee room; the full gate only protects against a corrupted count
    assign w_capture     = r_tok[LATENCY-1] && !w_full;
    assign w_beat_hs     = (r_state == S_STREAM) && bus.out_ready;
    assign w_tile_done   = w_beat_hs && (r_idx == BEAT_LAST);
    assign w_more        = (w_fifo_count > CNT_W'(1)) || w_capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tok <= '0;
        end else begin
            r_tok[0] <= w_issue_acc;
            for (int i = 1; i < LATENCY; i++) begin
                r_tok[i] <= r_tok[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
        end else if (w_issue_acc && !w_tile_done) begin
            r_outstanding <= r_outstanding + 1'b1;
        end else if (!w_issue_acc && w_tile_done) begin
            r_outstanding <= r_outstanding - 1'b1;
        end
    end

    tmul_tile_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_capture),
        .i_wdata (bus.c_in),
        .i_pop   (w_tile_done),
        .o_rdata (w_head),
        .o_count (w_fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    if (!w_empty || w_capture) r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_beat_hs) begin
                        if (r_idx == BEAT_LAST) begin
                            r_idx <= '0;
                            if (!w_more) r_state <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.issue_ready = w_issue_ready;
    assign bus.out_valid   = (r_state == S_STREAM);
    assign bus.out_idx     = r_idx;
    assign bus.out_last    = (r_state == S_STREAM) && (r_idx == BEAT_LAST);
    assign bus.out_data    = (r_state == S_STREAM) ? w_head[r_idx] : '0;

`ifdef TMUL_DRAIN_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (bus.issue_valid && !w_issue_ready) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_tmul_result_drain.sv
// tb/tb_tmul_result_drain.sv - randomized bench for tmul_result_drain against a queue-based model
module tb_tmul_result_drain;
    import tmul_pkg::*;

    localparam int L = 8;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    tmul_result_drain_if bus();
`ifdef TMUL_DRAIN_ERR_EN
    logic err;
`endif

    tmul_result_drain #(.LATENCY(L), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
`ifdef TMUL_DRAIN_ERR_EN
        .err (err),
`endif
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: accepted issues become capture timestamps; captured tiles queue up
    int      cyc = 0;
    int      m_outst = 0;
    int      m_beat = 0;
    bit      m_err = 1'b0;
    int      cap_q[$];
    c_tile_t tiles[$];

    always @(posedge clk) begin
        bit acc, hs, done;
        if (rst) begin
            m_outst = 0; m_beat = 0; m_err = 1'b0;
            cap_q.delete(); tiles.delete();
        end else begin
            hs   = (tiles.size() > 0) && bus.out_ready;
            done = hs && (m_beat == 7);
            acc  = bus.issue_valid && (m_outst < D);
            if (bus.issue_valid && m_outst >= D) m_err = 1'b1;
            if (hs) m_beat = done ? 0 : m_beat + 1;
            if (done) void'(tiles.pop_front());
            if (cap_q.size() > 0 && cap_q[0] == cyc) begin
                tiles.push_back(bus.c_in);
                void'(cap_q.pop_front());
            end
            m_outst = m_outst + int'(acc) - int'(done);
            if (acc) cap_q.push_back(cyc + L);
        end
        cyc++;
    end

    function automatic logic exp_valid();
        return tiles.size() > 0;
    endfunction

    function automatic logic [63:0] exp_data();
        logic [2:0] b = m_beat[2:0];
        return (tiles.size() > 0) ? tiles[0][b] : 64'd0;
    endfunction

    task automatic rand_c_in();
        for (int k = 0; k < TMUL_COLS; k++) bus.c_in[k] = {$urandom, $urandom};
    endtask

    task automatic wait_idle();
        int n = 0;
        bus.issue_valid = 1'b0;
        bus.out_ready   = 1'b1;
        while ((tiles.size() > 0 || cap_q.size() > 0 || bus.out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL wait_idle timeout: out_valid=%0b required drain within 300 cycles", bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.issue_valid = 1'b0;
        bus.out_ready   = 1'b0;
        bus.c_in        = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %0b want 1", bus.issue_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
        checks++; if (bus.out_idx !== 3'd0) begin errors++; $display("FAIL reset_out_idx got %0d want 0", bus.out_idx); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %0b want 0", bus.out_last); end
`ifdef TMUL_DRAIN_ERR_EN
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_tile();
        int k;
        for (int c = 0; c < TMUL_COLS; c++) bus.c_in[c] = 64'h1000 + 64'(c);
        bus.out_ready   = 1'b1;
        bus.issue_valid = 1'b1;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        k = 1;
        while (!bus.out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k !== L + 1) begin errors++; $display("FAIL single_latency got %0d cycles want %0d", k, L + 1); end
        for (int j = 0; j < 8; j++) begin
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid beat %0d got %0b want 1", j, bus.out_valid); end
            checks++; if (bus.out_data !== 64'h1000 + 64'(j)) begin errors++; $display("FAIL single_data beat %0d got %h want %h", j, bus.out_data, 64'h1000 + 64'(j)); end
            checks++; if (bus.out_idx !== 3'(j)) begin errors++; $display("FAIL single_idx got %0d want %0d", bus.out_idx, j); end
            checks++; if (bus.out_last !== (j == 7)) begin errors++; $display("FAIL single_last beat %0d got %0b want %0b", j, bus.out_last, j == 7); end
            @(negedge clk);
        end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_after got out_valid=%0b want 0", bus.out_valid); end
    endtask

    task automatic test_credit();
        int  acc = 0;
        int  n = 0;
        bus.out_ready   = 1'b0;
        bus.issue_valid = 1'b1;
        rand_c_in();
        for (int i = 0; i < 20; i++) begin
            if (bus.issue_ready) acc++;
            @(negedge clk);
        end
        checks++; if (acc !== D) begin errors++; $display("FAIL credit_accepted got %0d want %0d", acc, D); end
        checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL credit_ready_low got %0b want 0", bus.issue_ready); end
        bus.issue_valid = 1'b0;
        bus.out_ready   = 1'b1;
        while (!(bus.out_valid && bus.out_last) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 40) begin errors++; $display("FAIL credit_last_timeout got none want beat 7 within 40"); end
        checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL credit_ready_same_cycle got %0b want 0", bus.issue_ready); end
        checks++; if (bus.out_data !== exp_data()) begin errors++; $display("FAIL credit_data got %h want %h", bus.out_data, exp_data()); end
        @(negedge clk);
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL credit_ready_return got %0b want 1", bus.issue_ready); end
        wait_idle();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 400; i++) begin
            checks++; if (bus.out_valid !== exp_valid()) begin errors++; $display("FAIL bp_valid cyc %0d got %0b want %0b", cyc, bus.out_valid, exp_valid()); end
            checks++; if (bus.out_data !== exp_data()) begin errors++; $display("FAIL bp_data cyc %0d got %h want %h", cyc, bus.out_data, exp_data()); end
            checks++; if (bus.out_idx !== 3'(m_beat)) begin errors++; $display("FAIL bp_idx cyc %0d got %0d want %0d", cyc, bus.out_idx, m_beat); end
            checks++; if (bus.out_last !== (exp_valid() && m_beat == 7)) begin errors++; $display("FAIL bp_last cyc %0d got %0b", cyc, bus.out_last); end
            checks++; if (bus.issue_ready !== (m_outst < D)) begin errors++; $display("FAIL bp_ready cyc %0d got %0b want %0b", cyc, bus.issue_ready, m_outst < D); end
            bus.out_ready   = ($urandom_range(0, 1) == 1);
            bus.issue_valid = ($urandom_range(0, 3) == 0);
            rand_c_in();
            @(negedge clk);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int run = 0;
        int maxrun = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            checks++; if (bus.out_data !== exp_data()) begin errors++; $display("FAIL b2b_data cyc %0d got %h want %h", cyc, bus.out_data, exp_data()); end
            if (bus.out_valid) run++;
            else begin
                if (run > maxrun) maxrun = run;
                run = 0;
            end
            bus.issue_valid = (i == 0 || i == 8);
            rand_c_in();
            @(negedge clk);
        end
        if (run > maxrun) maxrun = run;
        checks++; if (maxrun !== 16) begin errors++; $display("FAIL b2b_run got %0d consecutive beats want 16", maxrun); end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        bus.out_ready   = 1'b1;
        bus.issue_valid = 1'b1;
        rand_c_in();
        @(negedge clk);
        bus.issue_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %0b want 1", bus.issue_ready); end
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid) seen++;
            rand_c_in();
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_valid got %0d valid cycles want 0", seen); end
    endtask

`ifdef TMUL_DRAIN_ERR_EN
    task automatic test_err();
        int n = 0;
        bus.out_ready   = 1'b0;
        bus.issue_valid = 1'b1;
        rand_c_in();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (err !== m_err) begin errors++; $display("FAIL err_track step %0d got %0b want %0b", i, err, m_err); end
        end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %0b want 1", err); end
        bus.issue_valid = 1'b0;
        bus.out_ready   = 1'b1;
        while ((tiles.size() > 0 || bus.out_valid) && n < 60) begin
            checks++; if (bus.out_data !== exp_data()) begin errors++; $display("FAIL err_stream got %h want %h", bus.out_data, exp_data()); end
            checks++; if (bus.out_valid !== exp_valid()) begin errors++; $display("FAIL err_valid got %0b want %0b", bus.out_valid, exp_valid()); end
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 2 * 8) begin errors++; $display("FAIL err_beats got %0d want 16", n); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b want 1", err); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired got no finish want finish");
        $fatal(1);
    end

    initial begin
        bus.issue_valid = 1'b0;
        bus.out_ready   = 1'b0;
        bus.c_in        = '0;
        test_reset();
        test_single_tile();
        test_credit();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef TMUL_DRAIN_ERR_EN
        test_err();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmul_result_drain.md
# tmul_result_drain

Result-side companion to the 8-column pipelined FMA tile multiplier. It tracks every tile operation issued into the multiplier array and captures the 8×64-bit `c` vector when that operation reaches the array output. It buffers captured tiles and streams each one out as eight 64-bit beats over a valid/ready interface. It also issues credits back to the issue logic, because the FMA array cannot stall and results must never be lost.

## Interface
- `LATENCY`, 8: cycles from an accepted issue to valid `c` at the array output (one per FMA level); legal range 1..64.
- `DEPTH`, 2: tile buffer capacity in tiles; legal range 1..8.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `issue_valid` in 1: a tile op enters the multiplier this cycle.
- `issue_ready` out 1: drain has a free credit; an issue is accepted only when `issue_valid && issue_ready`.
- `c_in` in 8×64 (`c_tile_t`): multiplier array output, column 0..7.
- `out_valid` out 1: `out_data` holds a valid beat.
- `out_ready` in 1: downstream accepts the beat.
- `out_data` out 64: current beat, equal to `c[out_idx]` of the head tile.
- `out_idx` out 3: column index of the current beat, 0..7.
- `out_last` out 1: high on beat 7.
- `err` out 1: present only with `TMUL_DRAIN_ERR_EN`; sticky issue-overrun flag.

## Operation
- **Token pipe.** `LATENCY`-stage 1-bit shift register, loaded with an accepted issue. When a token exits the pipe, `c_in` is written into the tail of the tile FIFO that same cycle.
- **Credit accounting.**
  - `outstanding` = tokens in flight + FIFO occupancy, held as a registered counter of 0..DEPTH.
  - An accepted issue adds 1.
  - A handshake on the last beat (`out_valid && out_ready && out_last`) subtracts 1.
  - If both happen in the same cycle, the counter is unchanged.
- **`issue_ready`.** Equals `outstanding < DEPTH` and is computed from the registered count only. A credit freed in cycle t makes `issue_ready` high in t+1, not in t.
- **FIFO never overflows.** Capture cannot find the FIFO full, because credits bound in-flight tokens plus occupancy.
- **Beat sequencer.**
  - States are IDLE and STREAM.
  - IDLE → STREAM when the FIFO is non-empty; `out_idx` = 0.
  - In STREAM, each `out_valid && out_ready` advances `out_idx`.
  - A handshake at `out_idx` = 7 pops the head tile. The sequencer then goes to STREAM with `out_idx` = 0 if another tile is present, otherwise to IDLE.
  - `out_data`, `out_idx` and `out_last` hold stable while `out_valid && !out_ready`.
- **Back-to-back tiles.** No bubble between beat 7 of one tile and beat 0 of the next.
- **Capture and pop in the same cycle.** Both are allowed; occupancy is unchanged.
- **`issue_valid` while `issue_ready` is low.** The issue is ignored: no token, no count change.

## Timing
- **Reset values.** `issue_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_idx` = 0, `out_last` = 0, `err` = 0. The token pipe, FIFO and counters are cleared.
- **Issue to first beat.** An issue accepted in cycle t is captured at the end of cycle t+LATENCY. `out_valid` rises in t+LATENCY+1 if the FIFO was empty and the sequencer was IDLE.
- **Steady-state throughput.** One beat per cycle with `out_ready` held high. One tile per 8 cycles, so sustained issue is also one per 8 cycles.
- **Reset mid-operation.** All in-flight tokens and buffered tiles are discarded. Array results that emerge after reset are never captured.

## Configuration
- **`TMUL_DRAIN_ERR_EN` defined.**
  - Adds the `err` port.
  - `err` is set one cycle after any cycle with `issue_valid && !issue_ready`.
  - It stays set until `rst`.
  - The offending issue is still dropped.
- **`TMUL_DRAIN_ERR_EN` not defined.** No `err` port and no detection logic. Ignored issues are silent.

## Structure
- **`tmul_pkg`.**
  - Typedef `c_tile_t` (`logic [63:0]` ×8).
  - Constants `TMUL_COLS` = 8 and `TMUL_ACC_W` = 64.
  - Beat-index typedef (3 bits).
- **Sub-module `tmul_tile_fifo`.** A `DEPTH`-entry FIFO of `c_tile_t` with registered read data, push/pop and full/empty flags. Pointers wrap modulo `DEPTH` with an explicit compare, since `DEPTH` need not be a power of 2.
- **Top level.** Holds the token pipe, credit counter, beat sequencer and optional error flag.

## Test plan
- **Single tile.** After reset, issue once at cycle 2 with `c_in` column k = 64'h1000+k held stable, `out_ready` = 1 → `out_valid` from cycle 11 (LATENCY = 8). Beats 0..7 carry 64'h1000..64'h1007, with `out_last` only on the 8th beat.
- **Credit exhaustion.** Hold `issue_valid` = 1 with `out_ready` = 0, DEPTH = 2 → exactly 2 issues are accepted and `issue_ready` = 0 from cycle 3. Raising `out_ready` returns `issue_ready` to 1 the cycle after beat 7 of tile 0.
- **Backpressure mid-tile.** Toggle `out_ready` 1,0,0,1… → `out_data` and `out_idx` hold during stalls, all 8 beats arrive in order, and nothing is lost or duplicated.
- **Back-to-back tiles.** Two issues 8 cycles apart, distinct `c_in` patterns, `out_ready` = 1 → 16 consecutive valid beats with no gap.
- **Reset mid-flight.** Assert `rst` 3 cycles after an issue → no `out_valid` ever appears for that tile, and `issue_ready` = 1 the cycle after reset.
- **Error flag (with `TMUL_DRAIN_ERR_EN`).** Issue while `issue_ready` = 0 → `err` = 1 the next cycle and it stays high. The output stream contains only the accepted tiles.
